// File: rtl/mod_fold_pkg.sv
// mod_fold_pkg: shared types and helpers for the fold reducer.
// State enum, modulus address helper, fold-count width helper.
package mod_fold_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_FOLD,
      ST_SUB,
      ST_DONE
   } state_e;

   // Config address of the modulus register (one past the table).
   function automatic int mod_addr(input int mb);
      return 1 << mb;
   endfunction

   // Bits needed to count 0..n-1.
   function automatic int cnt_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/mod_fold_corr_table.sv
// mod_fold_corr_table: 2^MB x W correction register file.
// Ports: clk, rst_n (sync, low), one write port (we_i/waddr_i/wdata_i),
// one combinational read port (raddr_i -> rdata_o).
module mod_fold_corr_table #(
   parameter int W  = 89,
   parameter int MB = 3
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          we_i,
   input  logic [MB-1:0] waddr_i,
   input  logic [W-1:0]  wdata_i,
   input  logic [MB-1:0] raddr_i,
   output logic [W-1:0]  rdata_o
);

   logic [W-1:0] mem_q [2**MB];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < 2**MB; i++) begin
            mem_q[i] <= '0;
         end
      end else if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/mod_fold_reduce.sv
// mod_fold_reduce: programmable overflow-folding modular reducer.
// Ports: clk, rst_n (sync, low); cfg_we/cfg_addr/cfg_wdata table and
// modulus writes; in_valid/in_ready/in_data {M,low} input handshake;
// out_valid/out_ready/out_data/out_err output handshake.
// Macro MOD_FOLD_FINAL_SUB_EN adds the modulus register and SUB state.
module mod_fold_reduce
   import mod_fold_pkg::*;
#(
   parameter int W         = 89,
   parameter int MB        = 3,
   parameter int MAX_FOLDS = 3
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          cfg_we,
   input  logic [MB:0]   cfg_addr,
   input  logic [W-1:0]  cfg_wdata,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [W+MB-1:0] in_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [W-1:0]  out_data,
   output logic          out_err
);

   localparam int CW = cnt_w(MAX_FOLDS + 1);
   localparam logic [CW-1:0] LAST = CW'(MAX_FOLDS - 1);

   state_e          state_q;
   logic [W-1:0]    low_q;
   logic [MB-1:0]   idx_q;
   logic [CW-1:0]   cnt_q;
   logic            out_valid_q;
   logic [W-1:0]    out_data_q;
   logic            out_err_q;

   logic            idle;
   logic            tbl_we;
   logic [W-1:0]    corr;
   logic [W:0]      sum_d;

   assign idle     = (state_q == ST_IDLE);
   assign in_ready = idle;
   // Config is only accepted while idle; cfg_addr[MB] set means
   // the address is outside the table.
   assign tbl_we   = cfg_we && idle && !cfg_addr[MB];
   assign sum_d    = {1'b0, low_q} + {1'b0, corr};

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_err   = out_err_q;

   mod_fold_corr_table #(
      .W  (W),
      .MB (MB)
   ) u_table (
      .clk     (clk),
      .rst_n   (rst_n),
      .we_i    (tbl_we),
      .waddr_i (cfg_addr[MB-1:0]),
      .wdata_i (cfg_wdata),
      .raddr_i (idx_q),
      .rdata_o (corr)
   );

`ifdef MOD_FOLD_FINAL_SUB_EN
   localparam logic [MB:0] MOD_A = (MB+1)'(mod_addr(MB));

   logic [W-1:0] mod_q;
   logic         sub_ok;

   assign sub_ok = (mod_q != '0) && (low_q >= mod_q);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mod_q <= '0;
      end else if (cfg_we && idle && cfg_addr == MOD_A) begin
         mod_q <= cfg_wdata;
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         low_q       <= '0;
         idx_q       <= '0;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_err_q   <= 1'b0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (in_valid) begin
                  low_q   <= in_data[W-1:0];
                  idx_q   <= in_data[W+MB-1:W];
                  cnt_q   <= '0;
                  state_q <= ST_FOLD;
               end
            end
            ST_FOLD: begin
               low_q <= sum_d[W-1:0];
               // Carry out becomes the next overflow index.
               idx_q <= MB'(sum_d[W]);
               cnt_q <= cnt_q + CW'(1);
               if (!sum_d[W]) begin
`ifdef MOD_FOLD_FINAL_SUB_EN
                  state_q <= ST_SUB;
`else
                  state_q     <= ST_DONE;
                  out_valid_q <= 1'b1;
                  out_data_q  <= sum_d[W-1:0];
                  out_err_q   <= 1'b0;
`endif
               end else if (cnt_q == LAST) begin
                  state_q     <= ST_DONE;
                  out_valid_q <= 1'b1;
                  out_data_q  <= sum_d[W-1:0];
                  out_err_q   <= 1'b1;
               end
            end
            ST_SUB: begin
`ifdef MOD_FOLD_FINAL_SUB_EN
               // Reached only without a fold-limit error.
               state_q     <= ST_DONE;
               out_valid_q <= 1'b1;
               out_err_q   <= 1'b0;
               out_data_q  <= sub_ok ? low_q - mod_q : low_q;
`else
               state_q <= ST_IDLE;
`endif
            end
            ST_DONE: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  state_q     <= ST_IDLE;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mod_fold_reduce.sv
// tb_mod_fold_reduce: randomized self-checking bench for mod_fold_reduce.
// Two instances (MAX_FOLDS=3 and 1) share clock, reset and config data.
module tb_mod_fold_reduce;

`ifdef MOD_FOLD_FINAL_SUB_EN
   localparam bit FS = 1'b1;
`else
   localparam bit FS = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n;
   logic [2:0] cfg_addr;
   logic [7:0] cfg_wdata;
   logic       cfg_we0, cfg_we1;
   logic       iv0, iv1, ir0, ir1;
   logic [9:0] id0, id1;
   logic       ov0, ov1, or0, or1;
   logic [7:0] od0, od1;
   logic       oe0, oe1;

   int n_cmp = 0;
   int n_bad = 0;
   int corr_m [4];
   int mod_m;

   always #5 clk = ~clk;

   mod_fold_reduce #(.W(8), .MB(2), .MAX_FOLDS(3)) u_dut0 (
      .clk       (clk),
      .rst_n     (rst_n),
      .cfg_we    (cfg_we0),
      .cfg_addr  (cfg_addr),
      .cfg_wdata (cfg_wdata),
      .in_valid  (iv0),
      .in_ready  (ir0),
      .in_data   (id0),
      .out_valid (ov0),
      .out_ready (or0),
      .out_data  (od0),
      .out_err   (oe0)
   );

   mod_fold_reduce #(.W(8), .MB(2), .MAX_FOLDS(1)) u_dut1 (
      .clk       (clk),
      .rst_n     (rst_n),
      .cfg_we    (cfg_we1),
      .cfg_addr  (cfg_addr),
      .cfg_wdata (cfg_wdata),
      .in_valid  (iv1),
      .in_ready  (ir1),
      .in_data   (id1),
      .out_valid (ov1),
      .out_ready (or1),
      .out_data  (od1),
      .out_err   (oe1)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic logic g_ov(input bit s);
      return s ? ov1 : ov0;
   endfunction
   function automatic logic g_ir(input bit s);
      return s ? ir1 : ir0;
   endfunction
   function automatic logic g_oe(input bit s);
      return s ? oe1 : oe0;
   endfunction
   function automatic logic [7:0] g_od(input bit s);
      return s ? od1 : od0;
   endfunction

   // Reference: repeated fold of the overflow index, then optional
   // single conditional subtraction.
   task automatic model(input int x, input int maxf, output int res,
                        output int err, output int folds);
      int low, m, t;
      low = x % 256;
      m = x / 256;
      folds = 0;
      do begin
         t = low + corr_m[m];
         low = t % 256;
         m = t / 256;
         folds++;
      end while (m != 0 && folds < maxf);
      err = (m != 0) ? 1 : 0;
      if (FS && err == 0 && mod_m != 0 && low >= mod_m) low = low - mod_m;
      res = low;
   endtask

   task automatic cfg_wr(input int addr, input int data);
      cfg_addr = addr[2:0];
      cfg_wdata = data[7:0];
      cfg_we0 = 1'b1;
      cfg_we1 = 1'b1;
      @(posedge clk); #1;
      cfg_we0 = 1'b0;
      cfg_we1 = 1'b0;
      if (addr < 4) corr_m[addr] = data;
      else if (addr == 4 && FS) mod_m = data;
   endtask

   // inj: 0 none, 1 cfg write during FOLD, 2 reset pulse during FOLD.
   task automatic run(input bit s, input int x, input int hold,
                      input int inj);
      int res, err, folds, lat, maxf;
      maxf = s ? 1 : 3;
      model(x, maxf, res, err, folds);
      chk("in_ready_idle", g_ir(s), 1);
      if (s) begin iv1 = 1'b1; id1 = x[9:0]; end
      else begin iv0 = 1'b1; id0 = x[9:0]; end
      @(posedge clk); #1;
      iv0 = 1'b0;
      iv1 = 1'b0;
      chk("in_ready_busy", g_ir(s), 0);
      if (inj == 1) begin
         cfg_addr = 3'd3;
         cfg_wdata = 8'hAA;
         cfg_we0 = 1'b1;
      end
      if (inj == 2) begin
         rst_n = 1'b0;
         @(posedge clk); #1;
         rst_n = 1'b1;
         chk("rst_mid_ov", g_ov(s), 0);
         chk("rst_mid_ir", g_ir(s), 1);
         for (int i = 0; i < 4; i++) corr_m[i] = 0;
         mod_m = 0;
         return;
      end
      lat = 0;
      while (!g_ov(s) && lat < 20) begin
         @(posedge clk); #1;
         cfg_we0 = 1'b0;
         lat++;
      end
      chk("out_valid", g_ov(s), 1);
      chk("latency", lat, folds + ((FS && err == 0) ? 1 : 0));
      chk("out_data", g_od(s), res);
      chk("out_err", g_oe(s), err);
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         chk("hold_ov", g_ov(s), 1);
         chk("hold_data", g_od(s), res);
         chk("hold_err", g_oe(s), err);
         chk("hold_ir", g_ir(s), 0);
      end
      if (s) or1 = 1'b1; else or0 = 1'b1;
      @(posedge clk); #1;
      or0 = 1'b0;
      or1 = 1'b0;
      chk("post_ov", g_ov(s), 0);
      chk("post_ir", g_ir(s), 1);
   endtask

   initial begin
      rst_n = 1'b0;
      cfg_addr = '0;
      cfg_wdata = '0;
      cfg_we0 = 1'b0;
      cfg_we1 = 1'b0;
      iv0 = 1'b0; iv1 = 1'b0;
      id0 = '0; id1 = '0;
      or0 = 1'b0; or1 = 1'b0;
      for (int i = 0; i < 4; i++) corr_m[i] = 0;
      mod_m = 0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      chk("rst_ov", ov0, 0);
      chk("rst_od", od0, 0);
      chk("rst_oe", oe0, 0);
      chk("rst_ir", ir0, 1);
      chk("rst_ir1", ir1, 1);

      cfg_wr(0, 0);
      cfg_wr(1, 5);
      cfg_wr(2, 10);
      cfg_wr(3, 15);
      cfg_wr(4, 251);
      cfg_wr(5, 77);

      run(0, 'h3FF, 0, 0);
      run(0, 'h0FA, 0, 0);
      run(0, 'h0FC, 0, 0);
      run(1, 'h3FF, 0, 0);
      run(0, 'h3FF, 5, 0);
      run(0, 'h3FF, 0, 1);
      run(0, 'h3FF, 0, 0);

      for (int k = 0; k < 60; k++) begin
         if (k % 10 == 0) begin
            for (int a = 0; a < 4; a++) cfg_wr(a, $urandom_range(0, 255));
            cfg_wr(4, ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 255));
         end
         run(1'($urandom_range(0, 1)), $urandom_range(0, 1023),
             $urandom_range(0, 3), 0);
      end

      cfg_wr(0, 0);
      cfg_wr(1, 5);
      cfg_wr(2, 10);
      cfg_wr(3, 15);
      cfg_wr(4, 251);
      run(0, 'h3FF, 0, 2);
      run(0, 'h3FF, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
